// File: rtl/ledstring_frame_seq_if.sv
// Word interface from the frame sequencer to the APA102-style ledstring serialiser.
// The master drives one word plus valid; the slave answers with a 1-cycle ack.
interface ledstring_frame_seq_if;
  logic       framing;
  logic       se_frame;
  logic [4:0] dat_glo;
  logic [7:0] dat_red;
  logic [7:0] dat_grn;
  logic [7:0] dat_blu;
  logic       valid;
  logic       ack;

  modport master (
    output framing, se_frame, dat_glo, dat_red, dat_grn, dat_blu, valid,
    input  ack
  );

  modport slave (
    input  framing, se_frame, dat_glo, dat_red, dat_grn, dat_blu, valid,
    output ack
  );
endinterface

// File: rtl/ledstring_frame_seq.sv
// Walks the pixel frame buffer and feeds ledstring one start frame, N_LEDS pixel
// words and END_WORDS end frames per refresh, optionally retriggering forever.
module ledstring_frame_seq #(
  parameter int N_LEDS    = 16,
  parameter int ADDR_W    = 8,
  parameter int END_WORDS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [4:0]            glo,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd,
  input  logic [23:0]           mem_rdata,
  ledstring_frame_seq_if.master word_if,
  output logic                  busy,
  output logic                  done
);

  localparam int                END_W    = (END_WORDS > 1) ? $clog2(END_WORDS) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_LEDS - 1);
  localparam logic [END_W-1:0]  LAST_END = END_W'(END_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_SOF_WAIT, S_FETCH, S_LOAD, S_PIX_WAIT, S_EOF, S_EOF_WAIT
  } state_t;

  // Every output is a flop; the FSM computes their next values alongside the state.
  typedef struct packed {
    logic              framing;
    logic              se_frame;
    logic [4:0]        glo;
    logic [23:0]       rgb;
    logic              valid;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              busy;
    logic              done;
  } out_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_pix,   w_pix;
  logic [END_W-1:0]  r_end,   w_end;
  out_t              r_out,   w_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pix   <= '0;
      r_end   <= '0;
      r_out   <= '0;
    end else begin
      // NOTE: state flops take non-blocking assignments only; the combinational
      // block below uses blocking ones and assigns every target first, so no latches.
      r_state <= w_state;
      r_pix   <= w_pix;
      r_end   <= w_end;
      r_out   <= w_out;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_pix        = r_pix;
    w_end        = r_end;
    w_out        = r_out;
    w_out.mem_rd = 1'b0;
    w_out.done   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // continuous only matters in the done cycle, which is the first idle cycle
        if (start || (r_out.done && continuous)) begin
          w_out.glo  = glo;
          w_out.busy = 1'b1;
          w_pix      = '0;
          w_state    = S_SOF;
        end
      end
      S_SOF: begin
        w_out.framing  = 1'b1;
        w_out.se_frame = 1'b0;
        w_out.valid    = 1'b1;
        w_state        = S_SOF_WAIT;
      end
      S_SOF_WAIT: begin
        if (word_if.ack) begin
          w_out.valid = 1'b0;
          w_state     = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state = S_LOAD;
      end
      S_LOAD: begin
        w_out.rgb     = mem_rdata;
        w_out.framing = 1'b0;
        w_out.valid   = 1'b1;
        w_state       = S_PIX_WAIT;
      end
      S_PIX_WAIT: begin
        if (word_if.ack) begin
          w_out.valid = 1'b0;
          if (r_pix == LAST_PIX) begin
            w_end   = '0;
            w_state = S_EOF;
          end else begin
            w_pix   = r_pix + 1'b1;
            w_state = S_FETCH;
          end
        end
      end
      S_EOF: begin
        w_out.framing  = 1'b1;
        w_out.se_frame = 1'b1;
        w_out.valid    = 1'b1;
        w_state        = S_EOF_WAIT;
      end
      S_EOF_WAIT: begin
        if (word_if.ack) begin
          w_out.valid = 1'b0;
          if (r_end == LAST_END) begin
            w_out.done = 1'b1;
            w_out.busy = 1'b0;
            w_state    = S_IDLE;
          end else begin
            w_end   = r_end + 1'b1;
            w_state = S_EOF;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Read strobe and address are registered on entry so they are live during FETCH.
    if (w_state == S_FETCH) begin
      w_out.mem_rd   = 1'b1;
      w_out.mem_addr = w_pix;
    end
  end

  assign word_if.framing  = r_out.framing;
  assign word_if.se_frame = r_out.se_frame;
  assign word_if.dat_glo  = r_out.glo;
  assign word_if.dat_red  = r_out.rgb[23:16];
  assign word_if.dat_grn  = r_out.rgb[15:8];
  assign word_if.dat_blu  = r_out.rgb[7:0];
  assign word_if.valid    = r_out.valid;
  assign mem_addr         = r_out.mem_addr;
  assign mem_rd           = r_out.mem_rd;
  assign busy             = r_out.busy;
  assign done             = r_out.done;

endmodule

// File: doc/ledstring_frame_seq.md
Name: ledstring_frame_seq

Overview:
- Upstream feeder for the APA102-style `ledstring` serialiser.
- On a start request it walks a pixel frame buffer (synchronous RAM, 1-cycle read latency) and issues one start frame, N_LEDS pixel words and END_WORDS end frames over the valid/ack word interface.
- Can self-retrigger for continuous refresh.
- Sits between the game/render logic that owns the frame buffer and `ledstring`.

Parameters:
- N_LEDS, 16, pixels per refresh; legal range is 1 to 2^ADDR_W.
- ADDR_W, 8, frame-buffer address width.
- END_WORDS, 1, number of all-ones end-frame words; at least 1, or ceil(N_LEDS/64) for long strings.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active low
- start  in  1  single-cycle request to begin a refresh; ignored while busy
- continuous  in  1  when 1, a new refresh starts automatically after each completed one
- glo  in  5  global brightness, sampled at refresh start
- mem_addr  out  ADDR_W  frame-buffer read address
- mem_rd  out  1  read strobe, 1 cycle
- mem_rdata  in  24  pixel data {red[23:16], grn[15:8], blu[7:0]}, valid the cycle after mem_rd
- framing  out  1  to ledstring: 1 = framing word, 0 = pixel
- se_frame  out  1  to ledstring: 0 = start frame, 1 = end frame
- dat_glo  out  5  to ledstring
- dat_red, dat_grn, dat_blu  out  8 each  to ledstring
- valid  out  1  to ledstring
- ack  in  1  from ledstring; 1-cycle pulse, arrives the cycle after the word is accepted
- busy  out  1  refresh in progress
- done  out  1  1-cycle pulse when the last end-frame ack is received

Behaviour:
- Reset values (async, rst_n=0): state IDLE, all outputs 0, internal pixel and end-word counters 0.
- Reset mid-refresh aborts immediately. valid drops asynchronously. No done pulse is issued.
- All outputs are registered. Word fields are stable whenever valid=1 and change only while valid=0.
- Handshake:
  - valid rises with the data and holds until ack=1 is sampled.
  - valid is 0 in the cycle after ack is seen.
  - At most one word is outstanding; a new word is never presented in the ack cycle.
- State machine:
  - IDLE: busy=0. On (start | restart_pending), latch glo into dat_glo, clear the pixel counter, set busy=1 and go to SOF.
  - SOF: framing=1, se_frame=0, valid=1. Go to SOF_WAIT.
  - SOF_WAIT: on ack, valid=0 and go to FETCH.
  - FETCH: mem_addr = pixel counter, mem_rd=1. Go to LOAD.
  - LOAD: capture mem_rdata into red/grn/blu, framing=0, valid=1. Go to PIX_WAIT.
  - PIX_WAIT: on ack, valid=0. If the counter equals N_LEDS-1, clear the end counter and go to EOF; otherwise increment the counter and go to FETCH.
  - EOF: framing=1, se_frame=1, valid=1. Go to EOF_WAIT.
  - EOF_WAIT: on ack, valid=0. If the end counter equals END_WORDS-1, pulse done, go to IDLE and set restart_pending = continuous; otherwise increment the end counter and go to EOF.
- Minimum word gap: framing words take 2 cycles from ack to the next valid; pixels take 3 cycles (FETCH + LOAD).
- mem_rd is asserted only in FETCH. mem_addr holds its value between fetches.
- start while busy=1 is dropped, not queued.
- start and continuous both high in IDLE start exactly one refresh.
- continuous is sampled only in the done cycle. Deasserting it mid-refresh finishes the current refresh, then stops.
- An ack while not in a *_WAIT state is ignored.
- glo changes mid-refresh do not take effect until the next refresh.
- N_LEDS=1: SOF, one pixel, EOF. The counter never increments.
- The pixel counter is ADDR_W bits. N_LEDS = 2^ADDR_W must reach address 2^ADDR_W-1 without wrapping early.

Test Plan:
- Reset, then a start pulse with glo=5'h1F, N_LEDS=4, RAM = 0xAA55EE, 0x9944DD, 0x8833CC, 0x7722BB; the model acks each word 1 cycle after acceptance.
  - Required words: SOF (framing=1, se_frame=0), then 4 pixels with red/grn/blu = AA/55/EE … 77/22/BB and dat_glo=1F, then 1 EOF.
  - mem_addr sequence 0,1,2,3; exactly 1 done pulse; busy low afterwards.
- Attach a real `ledstring` instance, N_LEDS=2.
  - led_data carries 32 zeros, then E0|glo followed by blu/grn/red per pixel, then 32 ones.
- Stall: the bench delays ack by 40 cycles on pixel 2.
  - valid stays 1 and data stays stable throughout; no mem_rd is issued during the stall.
- start pulses while busy, plus a glo change mid-frame.
  - No second refresh begins and dat_glo keeps its latched value; a start after done launches a new refresh.
- continuous=1 for 3 refreshes, then cleared mid-third.
  - Exactly 3 done pulses; the gap between done and the next SOF valid is 2 cycles; IDLE is held after the third.
- rst_n asserted in PIX_WAIT, pixel 1.
  - valid, busy and done go to 0 without a clock edge.
  - After release with no start, the block stays in IDLE with no mem_rd activity.
